// File: rtl/pred_raw_array.sv
// pred_raw_array: DEPTH-entry predicated read-add-write state array.
// Stage A registers every input; stage B evaluates the predicate and the
// selected branch, then commits to the entry and the output registers on
// the following edge.
// Optional saturating arithmetic and the o__sat output: define PRED_RAW_SAT_EN.
module pred_raw_array #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i__valid,
  input  logic [IDX_W-1:0] i__idx,
  input  logic [WIDTH-1:0] i__pkt_1,
  input  logic [WIDTH-1:0] i__pkt_2,
  input  logic [WIDTH-1:0] i__cons_1,
  input  logic [WIDTH-1:0] i__cons_2,
  input  logic [WIDTH-1:0] i__cons_3,
  input  logic             i__sel_1,
  input  logic [1:0]       i__sel_2,
  input  logic             i__sel_3,
  input  logic [1:0]       i__sel_4,
  input  logic             i__sel_5,
  input  logic [1:0]       i__sel_6,
  input  logic [2:0]       i__rel_opcode,
  input  logic             i__then_sub,
  input  logic             i__else_sub,
  output logic             o__valid,
  output logic [WIDTH-1:0] o__read,
  output logic [WIDTH-1:0] o__write,
  output logic             o__pred,
  output logic             o__oob
`ifdef PRED_RAW_SAT_EN
  ,
  output logic             o__sat
`endif
);

  localparam logic [IDX_W:0] DEPTH_W = (IDX_W+1)'(DEPTH);

  logic             v_a_q;
  logic [IDX_W-1:0] idx_a_q;
  logic [WIDTH-1:0] pkt1_a_q, pkt2_a_q, cons1_a_q, cons2_a_q, cons3_a_q;
  logic             sel1_a_q, sel3_a_q, sel5_a_q;
  logic [1:0]       sel2_a_q, sel4_a_q, sel6_a_q;
  logic [2:0]       op_a_q;
  logic             then_sub_a_q, else_sub_a_q;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             valid_q, pred_q, oob_q;
  logic [WIDTH-1:0] read_q, write_q;

  logic [IDX_W:0]   idx_ext;
  logic             in_range;
  logic [WIDTH-1:0] s, lhs_p, rhs_p, br_lhs, br_rhs, new_d;
  logic             pred_d, br_sub;
`ifdef PRED_RAW_SAT_EN
  logic [WIDTH:0]   sum_ext;
  logic             sat_d, sat_q;
`endif

  function automatic logic [WIDTH-1:0] mux3(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic [WIDTH-1:0] c,
                                            input logic [1:0] sel);
    case (sel)
      2'd0:    return a;
      2'd1:    return b;
      default: return c;
    endcase
  endfunction

  // Stage A: capture all inputs each cycle; reset clears the in-flight packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_a_q        <= 1'b0;
      idx_a_q      <= '0;
      pkt1_a_q     <= '0;
      pkt2_a_q     <= '0;
      cons1_a_q    <= '0;
      cons2_a_q    <= '0;
      cons3_a_q    <= '0;
      sel1_a_q     <= 1'b0;
      sel2_a_q     <= '0;
      sel3_a_q     <= 1'b0;
      sel4_a_q     <= '0;
      sel5_a_q     <= 1'b0;
      sel6_a_q     <= '0;
      op_a_q       <= '0;
      then_sub_a_q <= 1'b0;
      else_sub_a_q <= 1'b0;
    end else begin
      v_a_q        <= i__valid;
      idx_a_q      <= i__idx;
      pkt1_a_q     <= i__pkt_1;
      pkt2_a_q     <= i__pkt_2;
      cons1_a_q    <= i__cons_1;
      cons2_a_q    <= i__cons_2;
      cons3_a_q    <= i__cons_3;
      sel1_a_q     <= i__sel_1;
      sel2_a_q     <= i__sel_2;
      sel3_a_q     <= i__sel_3;
      sel4_a_q     <= i__sel_4;
      sel5_a_q     <= i__sel_5;
      sel6_a_q     <= i__sel_6;
      op_a_q       <= i__rel_opcode;
      then_sub_a_q <= i__then_sub;
      else_sub_a_q <= i__else_sub;
    end
  end

  // Stage B: entry read, unsigned predicate, branch select and arithmetic.
  always_comb begin
    idx_ext  = {1'b0, idx_a_q};
    in_range = idx_ext < DEPTH_W;
    s        = '0;
    if (in_range) s = mem_q[idx_a_q];

    lhs_p = sel1_a_q ? '0 : s;
    rhs_p = mux3(pkt1_a_q, pkt2_a_q, cons1_a_q, sel2_a_q);
    case (op_a_q)
      3'd0:    pred_d = lhs_p != rhs_p;
      3'd1:    pred_d = lhs_p <  rhs_p;
      3'd2:    pred_d = lhs_p >  rhs_p;
      3'd3:    pred_d = lhs_p == rhs_p;
      3'd4:    pred_d = lhs_p <= rhs_p;
      3'd5:    pred_d = lhs_p >= rhs_p;
      3'd6:    pred_d = 1'b1;
      default: pred_d = 1'b0;
    endcase

    if (pred_d) begin
      br_lhs = sel3_a_q ? '0 : s;
      br_rhs = mux3(pkt1_a_q, pkt2_a_q, cons2_a_q, sel4_a_q);
      br_sub = then_sub_a_q;
    end else begin
      br_lhs = sel5_a_q ? '0 : s;
      br_rhs = mux3(pkt1_a_q, pkt2_a_q, cons3_a_q, sel6_a_q);
      br_sub = else_sub_a_q;
    end

`ifdef PRED_RAW_SAT_EN
    sum_ext = {1'b0, br_lhs} + {1'b0, br_rhs};
    if (br_sub) begin
      sat_d = br_lhs < br_rhs;
      new_d = sat_d ? '0 : br_lhs - br_rhs;
    end else begin
      sat_d = sum_ext[WIDTH];
      new_d = sat_d ? '1 : sum_ext[WIDTH-1:0];
    end
`else
    new_d = br_sub ? br_lhs - br_rhs : br_lhs + br_rhs;
`endif
  end

  // State entries: cleared on reset, written by valid in-range packets.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (v_a_q && in_range) begin
      mem_q[idx_a_q] <= new_d;
    end
  end

  // Result registers: load on a valid packet, otherwise only drop valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      read_q  <= '0;
      write_q <= '0;
      pred_q  <= 1'b0;
      oob_q   <= 1'b0;
`ifdef PRED_RAW_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else if (v_a_q) begin
      valid_q <= 1'b1;
      if (in_range) begin
        read_q  <= s;
        write_q <= new_d;
        pred_q  <= pred_d;
        oob_q   <= 1'b0;
`ifdef PRED_RAW_SAT_EN
        sat_q   <= sat_d;
`endif
      end else begin
        read_q  <= '0;
        write_q <= '0;
        pred_q  <= 1'b0;
        oob_q   <= 1'b1;
`ifdef PRED_RAW_SAT_EN
        sat_q   <= 1'b0;
`endif
      end
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign o__valid = valid_q;
  assign o__read  = read_q;
  assign o__write = write_q;
  assign o__pred  = pred_q;
  assign o__oob   = oob_q;
`ifdef PRED_RAW_SAT_EN
  assign o__sat   = sat_q;
`endif

endmodule

// File: tb/tb_pred_raw_array.sv
// Bench for pred_raw_array (DEPTH = 12): directed packets with hand-computed
// results queued by the driver and consumed by an output monitor.
module tb_pred_raw_array;

  localparam int WIDTH = 32;
  localparam int DEPTH = 12;
  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             i__valid;
  logic [IDX_W-1:0] i__idx;
  logic [WIDTH-1:0] i__pkt_1, i__pkt_2, i__cons_1, i__cons_2, i__cons_3;
  logic             i__sel_1, i__sel_3, i__sel_5;
  logic [1:0]       i__sel_2, i__sel_4, i__sel_6;
  logic [2:0]       i__rel_opcode;
  logic             i__then_sub, i__else_sub;
  logic             o__valid, o__pred, o__oob;
  logic [WIDTH-1:0] o__read, o__write;
  logic             act_sat;
`ifdef PRED_RAW_SAT_EN
  logic             o__sat;
  assign act_sat = o__sat;
`else
  assign act_sat = 1'b0;
`endif

  pred_raw_array #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i__valid(i__valid), .i__idx(i__idx),
    .i__pkt_1(i__pkt_1), .i__pkt_2(i__pkt_2),
    .i__cons_1(i__cons_1), .i__cons_2(i__cons_2), .i__cons_3(i__cons_3),
    .i__sel_1(i__sel_1), .i__sel_2(i__sel_2), .i__sel_3(i__sel_3),
    .i__sel_4(i__sel_4), .i__sel_5(i__sel_5), .i__sel_6(i__sel_6),
    .i__rel_opcode(i__rel_opcode), .i__then_sub(i__then_sub), .i__else_sub(i__else_sub),
    .o__valid(o__valid), .o__read(o__read), .o__write(o__write),
    .o__pred(o__pred), .o__oob(o__oob)
`ifdef PRED_RAW_SAT_EN
    , .o__sat(o__sat)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] rd;
    logic [WIDTH-1:0] wr;
    logic             pred;
    logic             oob;
    logic             sat;
  } exp_t;

  exp_t             exp_q[$];
  exp_t             mon_e;
  logic [WIDTH-1:0] mem_m [DEPTH];
  int               errors = 0;
  int               checks = 0;
  int               pkt_n  = 0;

  // Drive one packet at the current falling edge and queue its expected result.
  // ew is the wrap-around result, ews the saturating one.
  task automatic send(input int idx, input int op,
                      input bit s1, input int s2, input logic [WIDTH-1:0] c1,
                      input bit s3, input int s4, input logic [WIDTH-1:0] c2, input bit ts,
                      input bit s5, input int s6, input logic [WIDTH-1:0] c3, input bit es,
                      input logic [WIDTH-1:0] p1, input logic [WIDTH-1:0] p2,
                      input logic [WIDTH-1:0] er, input logic [WIDTH-1:0] ew,
                      input logic [WIDTH-1:0] ews, input bit ep, input bit eo, input bit esat);
    exp_t e;
    i__valid = 1'b1;     i__idx = IDX_W'(idx);   i__rel_opcode = 3'(op);
    i__sel_1 = s1;       i__sel_2 = 2'(s2);      i__cons_1 = c1;
    i__sel_3 = s3;       i__sel_4 = 2'(s4);      i__cons_2 = c2;  i__then_sub = ts;
    i__sel_5 = s5;       i__sel_6 = 2'(s6);      i__cons_3 = c3;  i__else_sub = es;
    i__pkt_1 = p1;       i__pkt_2 = p2;
    e.rd = er; e.pred = ep; e.oob = eo;
`ifdef PRED_RAW_SAT_EN
    e.wr = ews; e.sat = esat;
`else
    e.wr = ew;  e.sat = 1'b0;
`endif
    exp_q.push_back(e);
    if (!eo) mem_m[idx] = e.wr;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    i__valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Read every entry by adding zero through the then branch.
  task automatic sweep();
    for (int i = 0; i < DEPTH; i++)
      send(i, 6, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0,
           mem_m[i], mem_m[i], mem_m[i], 1, 0, 0);
  endtask

  // Monitor: every o__valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (o__valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: o__valid=1 with no packet pending (read=%h write=%h)",
                 o__read, o__write);
      end else begin
        mon_e = exp_q.pop_front();
        if (o__read !== mon_e.rd || o__write !== mon_e.wr || o__pred !== mon_e.pred ||
            o__oob !== mon_e.oob || act_sat !== mon_e.sat) begin
          errors++;
          $display("FAIL pkt%0d: got read=%h write=%h pred=%b oob=%b sat=%b, want read=%h write=%h pred=%b oob=%b sat=%b",
                   pkt_n, o__read, o__write, o__pred, o__oob, act_sat,
                   mon_e.rd, mon_e.wr, mon_e.pred, mon_e.oob, mon_e.sat);
        end
        pkt_n++;
      end
    end
  end

  initial begin
    rst = 1'b1;
    i__valid = 1'b0; i__idx = '0; i__pkt_1 = '0; i__pkt_2 = '0;
    i__cons_1 = '0; i__cons_2 = '0; i__cons_3 = '0;
    i__sel_1 = 1'b0; i__sel_2 = '0; i__sel_3 = 1'b0; i__sel_4 = '0;
    i__sel_5 = 1'b0; i__sel_6 = '0; i__rel_opcode = '0;
    i__then_sub = 1'b0; i__else_sub = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    repeat (3) @(negedge clk);

    checks++;
    if (o__valid !== 1'b0 || o__read !== '0 || o__write !== '0 || o__pred !== 1'b0 ||
        o__oob !== 1'b0 || act_sat !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b read=%h write=%h pred=%b oob=%b sat=%b, want all 0",
               o__valid, o__read, o__write, o__pred, o__oob, act_sat);
    end
    rst = 1'b0;

    //   idx op s1 s2 c1  s3 s4 c2 ts  s5 s6 c3 es  p1 p2  read write wsat pred oob sat
    send(3, 6, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,  5, 0,  0, 5, 5, 1, 0, 0);
    send(3, 6, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,  1, 0,  5, 6, 6, 1, 0, 0);
    send(3, 6, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,  1, 0,  6, 7, 7, 1, 0, 0);
    send(3, 6, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,  1, 0,  7, 8, 8, 1, 0, 0);
    send(3, 6, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,  1, 0,  8, 9, 9, 1, 0, 0);
    // predicate s < cons_1 choosing then (+1) or else (+100)
    send(2, 6, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,  10, 0, 0, 10, 10, 1, 0, 0);
    send(2, 1, 0, 2, 20, 0, 2, 1, 0,  0, 2, 100, 0, 0, 0, 10, 11, 11, 1, 0, 0);
    send(4, 6, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,  10, 0, 0, 10, 10, 1, 0, 0);
    send(4, 1, 0, 2, 5,  0, 2, 1, 0,  0, 2, 100, 0, 0, 0, 10, 110, 110, 0, 0, 0);
    // add overflow and sub underflow
    send(5, 6, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,  32'hFFFF_FFFF, 0,
         0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 0);
    send(5, 6, 0, 0, 0,  0, 1, 0, 0,  0, 0, 0, 0,  0, 2,
         32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 1, 0, 1);
    send(6, 6, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,  3, 0,  0, 3, 3, 1, 0, 0);
    send(6, 6, 0, 0, 0,  0, 0, 0, 1,  0, 0, 0, 0,  5, 0,  3, 32'hFFFF_FFFE, 0, 1, 0, 1);
    // remaining opcodes, zero selects and else-branch sub on entry 7
    send(7, 7, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0, 0,  9, 0,  0, 9, 9, 0, 0, 0);
    send(7, 3, 0, 1, 0,  0, 2, 4, 1,  0, 0, 0, 0,  0, 9,  9, 5, 5, 1, 0, 0);
    send(7, 2, 0, 2, 5,  0, 0, 0, 0,  0, 2, 2, 0,  0, 0,  5, 7, 7, 0, 0, 0);
    send(7, 5, 0, 2, 7,  0, 2, 1, 0,  0, 0, 0, 0,  0, 0,  7, 8, 8, 1, 0, 0);
    send(7, 4, 0, 2, 7,  0, 0, 0, 0,  0, 2, 2, 0,  0, 0,  8, 10, 10, 0, 0, 0);
    send(7, 0, 0, 2, 10, 0, 0, 0, 0,  0, 2, 3, 1,  0, 0,  10, 7, 7, 0, 0, 0);
    send(7, 1, 1, 2, 1,  0, 2, 1, 0,  0, 0, 0, 0,  0, 0,  7, 8, 8, 1, 0, 0);
    // out-of-range indices: flagged, zeroed, no write
    send(13, 6, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  5, 0,  0, 0, 0, 0, 1, 0);
    send(12, 6, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  5, 0,  0, 0, 0, 0, 1, 0);
    sweep();
    idle(4);

    // reset lands while a packet to entry 1 sits in stage A
    i__valid = 1'b1; i__idx = 4'd1; i__rel_opcode = 3'd6;
    i__sel_3 = 1'b0; i__sel_4 = 2'd0; i__then_sub = 1'b0; i__pkt_1 = 32'd7;
    @(negedge clk);
    rst = 1'b1; i__valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    @(negedge clk);
    rst = 1'b0;
    send(1, 6, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,  3, 0,  0, 3, 3, 1, 0, 0);
    sweep();
    idle(1);

    for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results never appeared, want 0 pending", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
